// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the pipeline stall/flush controller.
// master = pipeline side raising requests, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        ex_start;
  logic [5:0]  ex_cycles;
  logic        ex_done;
  logic        flush_req;
  logic [31:0] new_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc_o;
  logic        busy;
  logic [31:0] stall_cnt;

  modport master (
    output stallreq_id, ex_start, ex_cycles, ex_done, flush_req, new_pc,
    input  stall, flush, new_pc_o, busy, stall_cnt
  );

  modport slave (
    input  stallreq_id, ex_start, ex_cycles, ex_done, flush_req, new_pc,
    output stall, flush, new_pc_o, busy, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: ID load-use stalls, multi-cycle EX stalls and flush redirects.
// Define PIPE_CTRL_EARLY_DONE_EN to let ex_done terminate an EX wait early.
module pipe_ctrl (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave pif
);

  typedef enum logic [1:0] {StRun, StExWait, StFlush} state_e;

  localparam logic [5:0] StallId = 6'b000111;
  localparam logic [5:0] StallEx = 6'b001111;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [5:0]  stall_c;
  logic [5:0]  stall_o;
  logic        early_done;

`ifdef PIPE_CTRL_EARLY_DONE_EN
  assign early_done = pif.ex_done;
`else
  logic unused_ex_done;
  assign early_done     = 1'b0;
  assign unused_ex_done = pif.ex_done;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    stall_c = '0;
    if (pif.flush_req) begin
      state_d = StFlush;
      cnt_d   = '0;
      pc_d    = pif.new_pc;
    end else begin
      unique case (state_q)
        StRun: begin
          // ex_cycles of 0 or 1 is a single-cycle op and never stalls.
          if (pif.ex_start && (pif.ex_cycles >= 6'd2)) begin
            stall_c = StallEx;
            state_d = StExWait;
            cnt_d   = pif.ex_cycles - 6'd2;
          end else if (pif.stallreq_id) begin
            stall_c = StallId;
          end
        end
        StExWait: begin
          if (early_done) begin
            cnt_d   = '0;
            state_d = StRun;
          end else if (cnt_q != '0) begin
            stall_c = StallEx;
            cnt_d   = cnt_q - 6'd1;
          end else begin
            state_d = StRun;
          end
        end
        StFlush: state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  // Reset must silence the combinational stall path immediately.
  assign stall_o = rst ? stall_c : '0;

  always_comb begin
    flush_d     = (state_d == StFlush);
    busy_d      = (state_d != StRun);
    stall_cnt_d = stall_cnt_q;
    if ((stall_o != '0) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pif.stall     = stall_o;
  assign pif.flush     = flush_q;
  assign pif.new_pc_o  = pc_q;
  assign pif.busy      = busy_q;
  assign pif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// queue-based model of the stall schedule.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_EARLY_DONE_EN
  localparam bit EarlyDone = 1'b1;
`else
  localparam bit EarlyDone = 1'b0;
`endif

  localparam logic [5:0] StallId = 6'b000111;
  localparam logic [5:0] StallEx = 6'b001111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

  // Model: pending EX_WAIT cycles as a queue (1 = stalled cycle, 0 = final idle cycle).
  bit          m_q[$];
  bit          m_flush;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] obs_stall;
  logic       obs_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_flush = 1'b0;
    m_pc    = '0;
    m_cnt   = '0;
  endtask

  // One clock cycle: entered at a negedge, leaves at the next negedge.
  task automatic cyc(input bit sid, input bit es, input logic [5:0] ec, input bit ed,
                     input bit fr, input logic [31:0] npc);
    logic [5:0] exp_stall;
    pif.stallreq_id = sid;
    pif.ex_start    = es;
    pif.ex_cycles   = ec;
    pif.ex_done     = ed;
    pif.flush_req   = fr;
    pif.new_pc      = npc;
    #1;
    if (fr)                     exp_stall = '0;
    else if (m_q.size() > 0)    exp_stall = (EarlyDone && ed) ? 6'b0 : (m_q[0] ? StallEx : 6'b0);
    else if (m_flush)           exp_stall = '0;
    else if (es && (ec >= 6'd2)) exp_stall = StallEx;
    else if (sid)               exp_stall = StallId;
    else                        exp_stall = '0;
    obs_stall = pif.stall;
    obs_busy  = pif.busy;
    check("stall",     {26'b0, pif.stall}, {26'b0, exp_stall});
    check("flush",     {31'b0, pif.flush}, {31'b0, m_flush});
    check("new_pc_o",  pif.new_pc_o, m_pc);
    check("busy",      {31'b0, pif.busy}, {31'b0, (m_flush || (m_q.size() > 0))});
    check("stall_cnt", pif.stall_cnt, m_cnt);
    if ((exp_stall != '0) && (m_cnt != 32'hFFFF_FFFF)) m_cnt++;
    if (fr) begin
      m_q.delete();
      m_flush = 1'b1;
      m_pc    = npc;
    end else if (m_q.size() > 0) begin
      if (EarlyDone && ed) m_q.delete();
      else void'(m_q.pop_front());
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (es && (ec >= 6'd2)) begin
      for (int i = 0; i < int'(ec) - 2; i++) m_q.push_back(1'b1);
      m_q.push_back(1'b0);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
  endtask

  // Asserts reset at a negedge with a live ID request, checks outputs before any clock edge.
  task automatic mid_reset(input string tag);
    rst = 1'b0;
    pif.stallreq_id = 1'b1;
    #1;
    check({tag, "_stall"},     {26'b0, pif.stall}, 32'h0);
    check({tag, "_flush"},     {31'b0, pif.flush}, 32'h0);
    check({tag, "_busy"},      {31'b0, pif.busy}, 32'h0);
    check({tag, "_new_pc_o"},  pif.new_pc_o, 32'h0);
    check({tag, "_stall_cnt"}, pif.stall_cnt, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  int cnt_a, cnt_b;
  logic [31:0] rpc;

  initial begin
    rst = 1'b0;
    pif.stallreq_id = 1'b0;
    pif.ex_start    = 1'b0;
    pif.ex_cycles   = '0;
    pif.ex_done     = 1'b0;
    pif.flush_req   = 1'b0;
    pif.new_pc      = '0;
    model_reset();
    #2;
    check("rst_stall",     {26'b0, pif.stall}, 32'h0);
    check("rst_flush",     {31'b0, pif.flush}, 32'h0);
    check("rst_busy",      {31'b0, pif.busy}, 32'h0);
    check("rst_new_pc_o",  pif.new_pc_o, 32'h0);
    check("rst_stall_cnt", pif.stall_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ID stall for two cycles.
    cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    check("id_stall0", {26'b0, obs_stall}, {26'b0, StallId});
    cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    check("id_stall1", {26'b0, obs_stall}, {26'b0, StallId});
    check("id_cnt", pif.stall_cnt, 32'd2);
    check("id_busy", {31'b0, pif.busy}, 32'h0);
    idle();

    // EX op of 5 cycles: 4 stalled cycles, 3 of them while busy.
    cnt_a = 0; cnt_b = 0;
    cyc(1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0);
    if (obs_stall == StallEx) cnt_a++;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (obs_stall == StallEx) cnt_a++;
      if (obs_stall == StallEx && obs_busy) cnt_b++;
    end
    check("ex5_stalls", cnt_a, 32'd4);
    check("ex5_busy_stalls", cnt_b, 32'd3);

    // Flush over an 8-cycle EX op.
    cyc(1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 32'h0);
    idle();
    idle();
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'hBFC0_0380);
    check("fl_flush", {31'b0, pif.flush}, 32'h1);
    check("fl_pc", pif.new_pc_o, 32'hBFC0_0380);
    idle();
    check("fl_after_flush", {31'b0, pif.flush}, 32'h0);
    check("fl_after_busy", {31'b0, pif.busy}, 32'h0);
    idle();

    // Flush, EX start and ID stall together: EX op dropped.
    cyc(1'b1, 1'b1, 6'd6, 1'b0, 1'b1, 32'h1234_5678);
    check("sim_stall", {26'b0, obs_stall}, 32'h0);
    check("sim_flush", {31'b0, pif.flush}, 32'h1);
    idle();
    check("sim_run", {31'b0, pif.busy}, 32'h0);
    idle();

    // Flush during flush re-latches the target and extends FLUSH.
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'hAAAA_0000);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 32'h5555_0004);
    check("ff_pc", pif.new_pc_o, 32'h5555_0004);
    check("ff_flush", {31'b0, pif.flush}, 32'h1);
    idle();
    idle();

    // 10-cycle EX op with ex_done on the 3rd EX_WAIT cycle.
    cnt_a = 0;
    cyc(1'b0, 1'b1, 6'd10, 1'b0, 1'b0, 32'h0);
    if (obs_stall == StallEx) cnt_a++;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 6'd0, (i == 3), 1'b0, 32'h0);
      if (obs_stall == StallEx) cnt_a++;
    end
    check("ex10_stalls", cnt_a, EarlyDone ? 32'd3 : 32'd9);

    // Reset in the middle of EX_WAIT.
    cyc(1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 32'h0);
    idle();
    mid_reset("mrst");
    cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    check("mrst_run_id", {26'b0, obs_stall}, {26'b0, StallId});

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        mid_reset("rnd_rst");
      end else begin
        rpc = $urandom();
        cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 10)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), rpc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: stallreq_id  in  1  ID load-use hazard request, level.
REQ-004 SHALL have: ex_start  in  1  one-cycle pulse, EX begins a multi-cycle op.
REQ-005 SHALL have: ex_cycles  in  6  total EX cycles of that op, sampled with ex_start.
REQ-006 SHALL have: ex_done  in  1  EX early-completion pulse.
REQ-007 SHALL have: flush_req  in  1  exception/redirect request, pulse.
REQ-008 SHALL have: new_pc  in  32  redirect target, sampled with flush_req.
REQ-009 SHALL have: stall  out  6  stall vector: [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb.
REQ-010 SHALL have: flush  out  1  pipeline flush, registered.
REQ-011 SHALL have: new_pc_o  out  32  redirect target, valid while flush=1.
REQ-012 SHALL have: busy  out  1  high when state is not RUN.
REQ-013 SHALL have: stall_cnt  out  32  saturating count of cycles with stall!=0.

Function
REQ-014 SHALL implement FSM states RUN, EX_WAIT, FLUSH; state, counter, flush, new_pc_o and stall_cnt registered.
REQ-015 stall SHALL be combinational from state and inputs (same-cycle response).
REQ-016 Priority SHALL be: flush_req > EX stall > ID stall.
REQ-017 RUN, stallreq_id=1, no other request: stall=6'b000111 the same cycle, state stays RUN.
REQ-018 RUN, ex_start=1, N=ex_cycles (0 treated as 1): N<=1 gives no stall; N>=2 gives stall=6'b001111 that cycle, state->EX_WAIT, counter loaded with N-2.
REQ-019 EX_WAIT: counter!=0 gives stall=6'b001111 and counter decrements; counter==0 gives stall=0 and state->RUN; total stalled cycles = N-1.
REQ-020 stallreq_id SHALL be ignored in EX_WAIT (EX stall already covers ID).
REQ-021 Any state, flush_req=1: stall=0 that cycle, new_pc latched, counter cleared, state->FLUSH; ex_start in the same cycle is dropped.
REQ-022 FLUSH: flush=1 and new_pc_o=latched value for exactly one cycle, stall=0, then RUN; flush_req during FLUSH re-latches new_pc and holds FLUSH one further cycle.
REQ-023 flush SHALL be 0 in all states except FLUSH; new_pc_o holds its last value otherwise.
REQ-024 stall_cnt SHALL increment on every clk edge where stall!=0 and saturate at 32'hFFFFFFFF.
REQ-025 ex_start in EX_WAIT SHALL be ignored (protocol violation, no state change).

Reset
REQ-026 rst=0 SHALL asynchronously force: state=RUN, counter=0, stall=0, flush=0, new_pc_o=32'h0, busy=0, stall_cnt=0.
REQ-027 Reset asserted mid-EX_WAIT or mid-FLUSH SHALL abandon the operation; first cycle after release behaves as RUN.

Configuration
REQ-028 Macro PIPE_CTRL_EARLY_DONE_EN defined: in EX_WAIT, ex_done=1 gives stall=0 that cycle, counter cleared, state->RUN.
REQ-029 Macro undefined: ex_done SHALL be ignored; EX_WAIT exits only on counter==0 or flush_req.

Verification
REQ-030 ID stall: RUN, stallreq_id=1 for 2 cycles -> stall=6'b000111 for exactly those 2 cycles, busy=0, stall_cnt=2.
REQ-031 EX op: ex_start with ex_cycles=5 -> stall=6'b001111 for 4 consecutive cycles, busy=1 for 3 cycles, then RUN with stall=0.
REQ-032 Flush over EX: ex_cycles=8 in progress, flush_req with new_pc=32'hBFC00380 -> next cycle flush=1, new_pc_o=32'hBFC00380, stall=0, one cycle later RUN.
REQ-033 Simultaneous: flush_req, ex_start and stallreq_id in one cycle -> stall=0, EX op dropped, FLUSH next cycle.
REQ-034 Early done (macro defined): ex_cycles=10, ex_done on the 3rd EX_WAIT cycle -> stall=0 that cycle, RUN next; macro undefined -> 9 stall cycles.
REQ-035 Reset mid-op: rst=0 during EX_WAIT -> all outputs 0 immediately, before the next clk edge.
